// File: rtl/regfile_wport_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wport_arbiter
//
// Purpose:
//    Shares the single general-purpose register-file write port between the
//    WB stage, the timer-interrupt EPC save and the multi-cycle divider.
//    WB always wins and is passed through in the same cycle. The EPC save is
//    buffered for one entry and written in the first cycle without a WB
//    write. The divider takes whatever is left. If the divider is refused
//    for too long, a registered stall request asks the pipeline to bubble WB.
//
// Parameters:
//    STARVE_LIMIT : refused divider cycles before o_stall_req rises (1..15)
//    EPC_REG      : register index that receives the EPC save
//
// Ports:
//    i_clk          in   clock; all state changes on the rising edge
//    i_rst_n        in   asynchronous reset, active low
//    i_wb_we        in   WB write request
//    i_wb_waddr     in   WB destination register
//    i_wb_wdata     in   WB write data
//    i_int_req      in   one-cycle pulse requesting the EPC save
//    i_int_data     in   EPC value captured with i_int_req
//    i_div_valid    in   divider result available
//    i_div_waddr    in   divider destination register
//    i_div_wdata    in   divider result
//    o_div_ready    out  divider result is consumed this cycle
//    o_rf_we        out  register-file write enable
//    o_rf_waddr     out  register-file write address
//    o_rf_wdata     out  register-file write data
//    o_int_busy     out  EPC save pending
//    o_int_overrun  out  one-cycle pulse: a pending EPC save was overwritten
//    o_stall_req    out  asks the pipeline to hold off WB writes
// ---------------------------------------------------------------------------
module regfile_wport_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int EPC_REG      = 26
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_wb_we,
   input  logic [4:0]  i_wb_waddr,
   input  logic [31:0] i_wb_wdata,
   input  logic        i_int_req,
   input  logic [31:0] i_int_data,
   input  logic        i_div_valid,
   input  logic [4:0]  i_div_waddr,
   input  logic [31:0] i_div_wdata,
   output logic        o_div_ready,
   output logic        o_rf_we,
   output logic [4:0]  o_rf_waddr,
   output logic [31:0] o_rf_wdata,
   output logic        o_int_busy,
   output logic        o_int_overrun,
   output logic        o_stall_req
);

   localparam logic [3:0] LP_LIMIT   = 4'(STARVE_LIMIT);
   localparam logic [4:0] LP_EPC_REG = 5'(EPC_REG);
   localparam logic [3:0] LP_SC_MAX  = 4'd15;

   // -----------------------------------------------------------------------
   // State
   // -----------------------------------------------------------------------
   logic        r_int_pend;
   logic [31:0] r_int_q;
   logic [3:0]  r_sc;
   logic        r_stall_req;
   logic        r_int_overrun;

   // -----------------------------------------------------------------------
   // Grant decode
   // -----------------------------------------------------------------------
   logic        w_wb_grant;
   logic        w_epc_grant;
   logic        w_div_grant;
   logic [3:0]  w_sc_next;
   logic        w_stall_next;

   always_comb begin
      w_wb_grant  = 1'b0;
      w_epc_grant = 1'b0;
      w_div_grant = 1'b0;
      // Every grant is forced off while reset is asserted so the
      // combinational outputs are quiet as well as the registered ones.
      if (i_rst_n) begin
         // A WB write to r0 is treated as no request at all, so it never
         // blocks the EPC save or the divider.
         if (i_wb_we && (i_wb_waddr != 5'd0)) begin
            w_wb_grant = 1'b1;
         end else if (r_int_pend) begin
            w_epc_grant = 1'b1;
         end else if (i_div_valid) begin
            w_div_grant = 1'b1;
         end
      end
   end

   // -----------------------------------------------------------------------
   // Write-port mux
   // -----------------------------------------------------------------------
   always_comb begin
      o_rf_we     = 1'b0;
      o_rf_waddr  = 5'd0;
      o_rf_wdata  = 32'd0;
      o_div_ready = 1'b0;
      if (w_wb_grant) begin
         o_rf_we    = 1'b1;
         o_rf_waddr = i_wb_waddr;
         o_rf_wdata = i_wb_wdata;
      end else if (w_epc_grant) begin
         o_rf_we    = 1'b1;
         o_rf_waddr = LP_EPC_REG;
         o_rf_wdata = r_int_q;
      end else if (w_div_grant) begin
         o_div_ready = 1'b1;
         // A divide into r0 still completes its handshake, it simply
         // does not touch the register file.
         if (i_div_waddr != 5'd0) begin
            o_rf_we    = 1'b1;
            o_rf_waddr = i_div_waddr;
            o_rf_wdata = i_div_wdata;
         end
      end
   end

   // -----------------------------------------------------------------------
   // Starvation counter and stall request
   // -----------------------------------------------------------------------
   always_comb begin
      w_sc_next    = 4'd0;
      w_stall_next = r_stall_req;
      if (i_div_valid && !w_div_grant) begin
         w_sc_next = (r_sc == LP_SC_MAX) ? LP_SC_MAX : (r_sc + 4'd1);
      end
      // The handshake releases the stall; otherwise it rises on the edge
      // where the refused-cycle count lands on the limit and then holds.
      if (w_div_grant) begin
         w_stall_next = 1'b0;
      end else if (w_sc_next == LP_LIMIT) begin
         w_stall_next = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sc        <= 4'd0;
         r_stall_req <= 1'b0;
      end else begin
         r_sc        <= w_sc_next;
         r_stall_req <= w_stall_next;
      end
   end

   // -----------------------------------------------------------------------
   // EPC save buffer
   // -----------------------------------------------------------------------
   // A new request always lands in the buffer at the edge, so it is never
   // written in its arrival cycle. If the old entry is being written this
   // same cycle nothing is lost; otherwise the old entry is replaced and
   // the loss is flagged.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_int_pend    <= 1'b0;
         r_int_q       <= 32'd0;
         r_int_overrun <= 1'b0;
      end else begin
         r_int_overrun <= i_int_req && r_int_pend && !w_epc_grant;
         if (i_int_req) begin
            r_int_q    <= i_int_data;
            r_int_pend <= 1'b1;
         end else if (w_epc_grant) begin
            r_int_pend <= 1'b0;
         end
      end
   end

   assign o_int_busy    = r_int_pend;
   assign o_int_overrun = r_int_overrun;
   assign o_stall_req   = r_stall_req;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wport_arbiter
//
// Self-checking bench for regfile_wport_arbiter. Inputs are driven 1 ns after
// the rising edge and outputs are sampled on the falling edge. Every
// expected register-file write is pushed to a queue when the stimulus that
// causes it is driven; a monitor pops and compares on each observed write.
// ---------------------------------------------------------------------------
module tb_regfile_wport_arbiter;

   logic        clk;
   logic        rst_n;
   logic        wb_we;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic        int_req;
   logic [31:0] int_data;
   logic        div_valid;
   logic [4:0]  div_waddr;
   logic [31:0] div_wdata;
   logic        div_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        int_busy;
   logic        int_overrun;
   logic        stall_req;

   int checks   = 0;
   int failures = 0;

   logic [36:0] exp_q[$];

   regfile_wport_arbiter #(
      .STARVE_LIMIT(4),
      .EPC_REG     (26)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_wb_we      (wb_we),
      .i_wb_waddr   (wb_waddr),
      .i_wb_wdata   (wb_wdata),
      .i_int_req    (int_req),
      .i_int_data   (int_data),
      .i_div_valid  (div_valid),
      .i_div_waddr  (div_waddr),
      .i_div_wdata  (div_wdata),
      .o_div_ready  (div_ready),
      .o_rf_we      (rf_we),
      .o_rf_waddr   (rf_waddr),
      .o_rf_wdata   (rf_wdata),
      .o_int_busy   (int_busy),
      .o_int_overrun(int_overrun),
      .o_stall_req  (stall_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard monitor: every observed write must match the oldest
   // outstanding expectation.
   always @(negedge clk) begin
      if (rf_we === 1'b1) begin
         logic [36:0] e;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write: got r%0d=0x%08h, required no write", rf_waddr, rf_wdata);
         end else begin
            e = exp_q.pop_front();
            if ({rf_waddr, rf_wdata} !== e) begin
               failures++;
               $display("FAIL write: got r%0d=0x%08h, required r%0d=0x%08h",
                        rf_waddr, rf_wdata, e[36:32], e[31:0]);
            end else begin
               $display("write r%0d=0x%08h ok", rf_waddr, rf_wdata);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wb_we     = 1'b0;
      wb_waddr  = 5'd0;
      wb_wdata  = 32'd0;
      int_req   = 1'b0;
      int_data  = 32'd0;
      div_valid = 1'b0;
      div_waddr = 5'd0;
      div_wdata = 32'd0;
   endtask

   task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
      wb_we    = 1'b1;
      wb_waddr = a;
      wb_wdata = d;
      exp_q.push_back({a, d});
   endtask

   task automatic test_reset();
      tick();
      rst_n     = 1'b0;
      wb_we     = 1'b1;
      wb_waddr  = 5'd5;
      wb_wdata  = 32'hDEAD;
      int_req   = 1'b1;
      int_data  = 32'hBEEF;
      div_valid = 1'b1;
      div_waddr = 5'd3;
      div_wdata = 32'h1;
      @(negedge clk);
      checks++;
      if ({div_ready, rf_we, rf_waddr, rf_wdata, int_busy, int_overrun, stall_req} !== 42'd0) begin
         failures++;
         $display("FAIL reset_outputs: got ready=%b we=%b addr=%0d data=0x%08h busy=%b ovr=%b stall=%b, required all 0",
                  div_ready, rf_we, rf_waddr, rf_wdata, int_busy, int_overrun, stall_req);
      end else $display("reset outputs zero ok");
      tick();
      idle_inputs();
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({rf_we, int_busy, stall_req, int_overrun} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_release: got we=%b busy=%b stall=%b ovr=%b, required 0000",
                  rf_we, int_busy, stall_req, int_overrun);
      end else $display("reset release idle ok");
   endtask

   task automatic test_wb_passthrough();
      tick();
      wb_write(5'd5, 32'h1234);
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b1 || div_ready !== 1'b0) begin
         failures++;
         $display("FAIL wb_same_cycle: got we=%b ready=%b, required we=1 ready=0", rf_we, div_ready);
      end else $display("wb pass-through ok");
      tick();
      wb_we    = 1'b1;
      wb_waddr = 5'd0;
      wb_wdata = 32'h5555;
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b0) begin
         failures++;
         $display("FAIL wb_r0: got we=%b, required 0", rf_we);
      end else $display("wb r0 suppressed ok");
      idle_inputs();
   endtask

   task automatic test_epc_blocked();
      tick();
      int_req  = 1'b1;
      int_data = 32'h0040_0020;
      @(negedge clk);
      checks++;
      if (int_busy !== 1'b0 || rf_we !== 1'b0) begin
         failures++;
         $display("FAIL epc_arrival: got busy=%b we=%b, required 0 0", int_busy, rf_we);
      end
      for (int c = 1; c <= 3; c++) begin
         tick();
         idle_inputs();
         if (c == 1) wb_write(5'd1, 32'h11);
         if (c == 2) wb_write(5'd2, 32'h22);
         if (c == 3) exp_q.push_back({5'd26, 32'h0040_0020});
         @(negedge clk);
         checks++;
         if (int_busy !== 1'b1) begin
            failures++;
            $display("FAIL epc_busy_c%0d: got %b, required 1", c, int_busy);
         end else $display("epc busy cycle %0d ok", c);
      end
      tick();
      @(negedge clk);
      checks++;
      if (int_busy !== 1'b0) begin
         failures++;
         $display("FAIL epc_busy_after: got %b, required 0", int_busy);
      end else $display("epc drained ok");
   endtask

   task automatic test_epc_overrun();
      logic [1:0] ovr_exp[4] = '{2'b0, 2'b0, 2'b1, 2'b0};
      for (int c = 0; c < 4; c++) begin
         tick();
         idle_inputs();
         wb_write(5'(3 + c), 32'h300 + 32'(c));
         if (c == 0) begin int_req = 1'b1; int_data = 32'hA0; end
         if (c == 1) begin int_req = 1'b1; int_data = 32'hB0; end
         @(negedge clk);
         checks++;
         if (int_overrun !== ovr_exp[c][0]) begin
            failures++;
            $display("FAIL overrun_c%0d: got %b, required %b", c, int_overrun, ovr_exp[c][0]);
         end else $display("overrun cycle %0d ok", c);
      end
      tick();
      idle_inputs();
      exp_q.push_back({5'd26, 32'hB0});
      tick();
      @(negedge clk);
      checks++;
      if (int_busy !== 1'b0 || int_overrun !== 1'b0) begin
         failures++;
         $display("FAIL overrun_drain: got busy=%b ovr=%b, required 0 0", int_busy, int_overrun);
      end else $display("overrun drained ok");
   endtask

   task automatic test_div_starvation();
      for (int c = 0; c < 5; c++) begin
         tick();
         idle_inputs();
         div_valid = 1'b1;
         div_waddr = 5'd9;
         div_wdata = 32'h77;
         wb_write(5'(10 + c), 32'h1000 + 32'(c));
         @(negedge clk);
         checks++;
         if (stall_req !== (c == 4) || div_ready !== 1'b0) begin
            failures++;
            $display("FAIL starve_c%0d: got stall=%b ready=%b, required stall=%b ready=0",
                     c, stall_req, div_ready, (c == 4));
         end else $display("starve cycle %0d ok", c);
      end
      tick();
      wb_we    = 1'b0;
      wb_waddr = 5'd0;
      exp_q.push_back({5'd9, 32'h77});
      @(negedge clk);
      checks++;
      if (div_ready !== 1'b1 || stall_req !== 1'b1) begin
         failures++;
         $display("FAIL starve_handshake: got ready=%b stall=%b, required 1 1", div_ready, stall_req);
      end else $display("divider handshake ok");
      tick();
      idle_inputs();
      @(negedge clk);
      checks++;
      if (stall_req !== 1'b0) begin
         failures++;
         $display("FAIL stall_release: got %b, required 0", stall_req);
      end else $display("stall released ok");
   endtask

   task automatic test_three_way();
      tick();
      int_req  = 1'b1;
      int_data = 32'hC0;
      for (int c = 1; c <= 3; c++) begin
         tick();
         idle_inputs();
         div_valid = 1'b1;
         div_waddr = 5'd11;
         div_wdata = 32'h55;
         if (c == 1) wb_write(5'd7, 32'h70);
         if (c == 2) exp_q.push_back({5'd26, 32'hC0});
         if (c == 3) exp_q.push_back({5'd11, 32'h55});
         @(negedge clk);
         checks++;
         if (div_ready !== (c == 3)) begin
            failures++;
            $display("FAIL three_way_ready_c%0d: got %b, required %b", c, div_ready, (c == 3));
         end else $display("three-way cycle %0d ok", c);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_div_r0();
      tick();
      div_valid = 1'b1;
      div_waddr = 5'd0;
      div_wdata = 32'h99;
      @(negedge clk);
      checks++;
      if (div_ready !== 1'b1 || rf_we !== 1'b0) begin
         failures++;
         $display("FAIL div_r0: got ready=%b we=%b, required 1 0", div_ready, rf_we);
      end else $display("divider r0 handshake ok");
      tick();
      idle_inputs();
   endtask

   task automatic test_reset_midop();
      tick();
      int_req  = 1'b1;
      int_data = 32'hD0;
      tick();
      idle_inputs();
      #2;
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (int_busy !== 1'b0 || rf_we !== 1'b0) begin
         failures++;
         $display("FAIL midop_reset: got busy=%b we=%b, required 0 0", int_busy, rf_we);
      end else $display("mid-operation reset ok");
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (int_busy !== 1'b0 || rf_we !== 1'b0) begin
         failures++;
         $display("FAIL midop_release: got busy=%b we=%b, required 0 0", int_busy, rf_we);
      end else $display("post-reset quiet ok");
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_wb_passthrough();
      test_epc_blocked();
      test_epc_overrun();
      test_div_starvation();
      test_three_way();
      test_div_r0();
      test_reset_midop();
      tick();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL missing_writes: got %0d outstanding, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
